// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte sources.
// Owns one frame at a time: start pulse, wait for busy, wait for done, then idle gap.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ    = 3,
   parameter int unsigned START_TO = 16,
   parameter int unsigned GAP      = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic [1:0]         grant_id,
   output logic               active,
   output logic               err_timeout
);

   localparam int unsigned TW = $clog2(START_TO + 1);

   typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StGap} state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   ready_q, ready_d;
   logic               start_q, start_d;
   logic               err_q, err_d;
   logic [7:0]         data_q, data_d;
   logic [1:0]         grant_q, grant_d;
   logic [1:0]         last_q, last_d;
   logic [7:0]         gap_cnt_q, gap_cnt_d;
   logic [TW-1:0]      timer_q, timer_d;

   logic               win_found;
   logic [1:0]         win_idx;
   logic [7:0]         win_data;

   // Round-robin pick: first pass above last_q, second pass wraps to 0..last_q.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req_valid[i] && (i > int'(last_q))) begin
            win_found = 1'b1;
            win_idx   = 2'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req_valid[i] && (i <= int'(last_q))) begin
            win_found = 1'b1;
            win_idx   = 2'(i);
         end
      end
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i == int'(win_idx)) win_data = req_data[8*i +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      ready_d   = '0;
      start_d   = 1'b0;
      err_d     = 1'b0;
      data_d    = data_q;
      grant_d   = grant_q;
      last_d    = last_q;
      gap_cnt_d = gap_cnt_q;
      timer_d   = timer_q;
      unique case (state_q)
         StIdle: begin
            if (win_found && !tx_busy) begin
               state_d = StWaitBusy;
               ready_d = N_REQ'(1) << win_idx;
               start_d = 1'b1;
               data_d  = win_data;
               grant_d = win_idx;
               last_d  = win_idx;
               timer_d = '0;
            end
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end else if (timer_q == TW'(START_TO - 1)) begin
               // Transmitter never started; the byte is still treated as consumed.
               err_d     = 1'b1;
               gap_cnt_d = '0;
               state_d   = (GAP == 0) ? StIdle : StGap;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               gap_cnt_d = '0;
               state_d   = (GAP == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            if (gap_cnt_q == 8'(GAP - 1)) state_d = StIdle;
            else                          gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         ready_q   <= '0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= 8'h00;
         grant_q   <= '0;
         last_q    <= 2'(N_REQ - 1);
         gap_cnt_q <= '0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         start_q   <= start_d;
         err_q     <= err_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         gap_cnt_q <= gap_cnt_d;
         timer_q   <= timer_d;
      end
   end

   assign req_ready   = ready_q;
   assign tx_start    = start_q;
   assign tx_data     = data_q;
   assign grant_id    = grant_q;
   assign err_timeout = err_q;
   assign active      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: default build plus a GAP=0 build.
// Expected grants go into a scoreboard queue when requests are driven.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_data = '0;
   logic [2:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_id;
   logic        active;
   logic        err_timeout;

   logic [2:0]  req_valid0 = '0;
   logic [23:0] req_data0 = '0;
   logic [2:0]  req_ready0;
   logic        tx_start0;
   logic [7:0]  tx_data0;
   logic        tx_busy0 = 1'b0;
   logic [1:0]  grant_id0;
   logic        active0;
   logic        err_timeout0;

   uart_tx_arbiter #(.N_REQ(3), .START_TO(16), .GAP(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
   );

   uart_tx_arbiter #(.N_REQ(3), .START_TO(16), .GAP(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_data(req_data0),
      .req_ready(req_ready0), .tx_start(tx_start0), .tx_data(tx_data0), .tx_busy(tx_busy0),
      .grant_id(grant_id0), .active(active0), .err_timeout(err_timeout0)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] id;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;

   // Transmitter model: busy rises 2 cycles after tx_start and stays high 10 cycles.
   bit   auto_busy = 1'b0;
   logic man_busy = 1'b0;
   int   phase = 0;
   always @(negedge clk) begin
      if (tx_start === 1'b1)             phase = 1;
      else if (phase != 0 && phase < 13) phase++;
      else                               phase = 0;
      tx_busy = auto_busy ? (phase >= 3 && phase <= 12) : man_busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      req_valid0 = '0;
      repeat (14) tick();
      reset = 1'b0;
   endtask

   task automatic wait_start(input int budget, output int cycles);
      cycles = 0;
      while (tx_start !== 1'b1 && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic pop_exp();
      if (sb.size() == 0) begin
         e.data = 8'hxx;
         e.id = 2'bxx;
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      total += 6;
      if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got %b want 000", req_ready); end
      if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_start got %b want 0", tx_start); end
      if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got %h want 00", tx_data); end
      if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant got %0d want 0", grant_id); end
      if (active !== 1'b0) begin bad++; $display("FAIL rst_active got %b want 0", active); end
      if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err_timeout); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      auto_busy = 1'b1;
      req_valid = 3'b001;
      req_data = {8'h00, 8'h00, 8'hA5};
      sb.push_back('{data: 8'hA5, id: 2'd0});
      tick();
      pop_exp();
      total += 5;
      if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start got %b want 1", tx_start); end
      if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got %b want 001", req_ready); end
      if (tx_data !== e.data) begin bad++; $display("FAIL single_data got %h want %h", tx_data, e.data); end
      if (grant_id !== e.id) begin bad++; $display("FAIL single_grant got %0d want %0d", grant_id, e.id); end
      if (active !== 1'b1) begin bad++; $display("FAIL single_active got %b want 1", active); end
      req_valid = '0;
      tick();
      total++;
      if ({req_ready, tx_start} !== 4'b0) begin
         bad++; $display("FAIL single_pulse got %b want 0000", {req_ready, tx_start});
      end
      repeat (13) tick();
      total++;
      if (active !== 1'b1) begin bad++; $display("FAIL single_gap_active got %b want 1", active); end
      tick();
      total++;
      if (active !== 1'b0) begin bad++; $display("FAIL single_idle_active got %b want 0", active); end
   endtask

   task automatic test_round_robin();
      int cyc;
      logic [7:0] bytes [3];
      bytes[0] = 8'h11;
      bytes[1] = 8'h22;
      bytes[2] = 8'h33;
      do_reset();
      req_valid = 3'b111;
      req_data = {8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 6; i++) sb.push_back('{data: bytes[i % 3], id: 2'(i % 3)});
      for (int i = 0; i < 6; i++) begin
         wait_start(40, cyc);
         pop_exp();
         total++;
         if (tx_start !== 1'b1) begin
            bad++; $display("FAIL rr_start[%0d] got %b want 1 within 40 cycles", i, tx_start);
         end else begin
            total += 3;
            if (tx_data !== e.data) begin bad++; $display("FAIL rr_data[%0d] got %h want %h", i, tx_data, e.data); end
            if (grant_id !== e.id) begin bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, grant_id, e.id); end
            if (req_ready !== (3'b001 << e.id)) begin
               bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, 3'b001 << e.id);
            end
         end
         tick();
         total++;
         if ({req_ready, tx_start} !== 4'b0) begin
            bad++; $display("FAIL rr_pulse[%0d] got %b want 0000", i, {req_ready, tx_start});
         end
      end
      req_valid = '0;
      repeat (20) tick();
   endtask

   task automatic test_timeout();
      auto_busy = 1'b0;
      man_busy = 1'b0;
      do_reset();
      req_valid = 3'b011;
      req_data = {8'h00, 8'hC3, 8'h5A};
      sb.push_back('{data: 8'h5A, id: 2'd0});
      sb.push_back('{data: 8'hC3, id: 2'd1});
      tick();
      pop_exp();
      total += 2;
      if (tx_start !== 1'b1) begin bad++; $display("FAIL to_start got %b want 1", tx_start); end
      if (grant_id !== e.id) begin bad++; $display("FAIL to_grant got %0d want %0d", grant_id, e.id); end
      repeat (15) tick();
      total++;
      if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err_early got %b want 0", err_timeout); end
      tick();
      total++;
      if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_pulse got %b want 1", err_timeout); end
      tick();
      total += 2;
      if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err_width got %b want 0", err_timeout); end
      if (active !== 1'b1) begin bad++; $display("FAIL to_gap_active got %b want 1", active); end
      tick();
      total++;
      if (active !== 1'b0) begin bad++; $display("FAIL to_idle_active got %b want 0", active); end
      tick();
      pop_exp();
      total += 4;
      if (tx_start !== 1'b1) begin bad++; $display("FAIL to_next_start got %b want 1", tx_start); end
      if (grant_id !== e.id) begin bad++; $display("FAIL to_next_grant got %0d want %0d", grant_id, e.id); end
      if (tx_data !== e.data) begin bad++; $display("FAIL to_next_data got %h want %h", tx_data, e.data); end
      if (req_ready !== 3'b010) begin bad++; $display("FAIL to_next_ready got %b want 010", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_busy_idle();
      int spurious = 0;
      do_reset();
      man_busy = 1'b1;
      req_valid = 3'b010;
      req_data = {8'h00, 8'h77, 8'h00};
      sb.push_back('{data: 8'h77, id: 2'd1});
      repeat (5) begin
         tick();
         if ({req_ready, tx_start} !== 4'b0) spurious++;
      end
      total++;
      if (spurious !== 0) begin bad++; $display("FAIL busy_hold got %0d grants want 0", spurious); end
      man_busy = 1'b0;
      tick();
      pop_exp();
      total += 3;
      if (tx_start !== 1'b1) begin bad++; $display("FAIL busy_release_start got %b want 1", tx_start); end
      if (grant_id !== e.id) begin bad++; $display("FAIL busy_release_grant got %0d want %0d", grant_id, e.id); end
      if (tx_data !== e.data) begin bad++; $display("FAIL busy_release_data got %h want %h", tx_data, e.data); end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      int early = 0;
      do_reset();
      auto_busy = 1'b1;
      req_valid = 3'b001;
      req_data = {8'h00, 8'h00, 8'hA5};
      sb.push_back('{data: 8'hA5, id: 2'd0});
      tick();
      pop_exp();
      total++;
      if (tx_data !== e.data) begin bad++; $display("FAIL mid_first_data got %h want %h", tx_data, e.data); end
      req_valid = '0;
      repeat (5) tick();
      req_valid = 3'b100;
      req_data = {8'h3C, 8'h00, 8'h00};
      sb.push_back('{data: 8'h3C, id: 2'd2});
      reset = 1'b1;
      tick();
      total++;
      if ({req_ready, tx_start, tx_data, grant_id, active, err_timeout} !== 15'b0) begin
         bad++; $display("FAIL mid_reset_outputs got %h want 0",
                         {req_ready, tx_start, tx_data, grant_id, active, err_timeout});
      end
      reset = 1'b0;
      for (int k = 7; k <= 12; k++) begin
         tick();
         if (tx_start !== 1'b0) early++;
      end
      total++;
      if (early !== 0) begin bad++; $display("FAIL mid_busy_hold got %0d starts want 0", early); end
      tick();
      pop_exp();
      total += 4;
      if (tx_start !== 1'b1) begin bad++; $display("FAIL mid_start got %b want 1", tx_start); end
      if (grant_id !== e.id) begin bad++; $display("FAIL mid_grant got %0d want %0d", grant_id, e.id); end
      if (tx_data !== e.data) begin bad++; $display("FAIL mid_data got %h want %h", tx_data, e.data); end
      if (req_ready !== 3'b100) begin bad++; $display("FAIL mid_ready got %b want 100", req_ready); end
      req_valid = '0;
      repeat (20) tick();
   endtask

   task automatic test_gap0();
      req_valid0 = 3'b011;
      req_data0 = {8'h00, 8'h55, 8'h44};
      sb.push_back('{data: 8'h44, id: 2'd0});
      sb.push_back('{data: 8'h55, id: 2'd1});
      tick();
      pop_exp();
      total += 2;
      if (tx_start0 !== 1'b1) begin bad++; $display("FAIL g0_start got %b want 1", tx_start0); end
      if (tx_data0 !== e.data) begin bad++; $display("FAIL g0_data got %h want %h", tx_data0, e.data); end
      tx_busy0 = 1'b1;
      repeat (3) tick();
      tx_busy0 = 1'b0;
      total++;
      if (active0 !== 1'b1) begin bad++; $display("FAIL g0_busy_active got %b want 1", active0); end
      tick();
      total++;
      if ({active0, tx_start0} !== 2'b00) begin
         bad++; $display("FAIL g0_idle got %b want 00", {active0, tx_start0});
      end
      tick();
      pop_exp();
      total += 3;
      if (tx_start0 !== 1'b1) begin bad++; $display("FAIL g0_next_start got %b want 1", tx_start0); end
      if (grant_id0 !== e.id) begin bad++; $display("FAIL g0_next_grant got %0d want %0d", grant_id0, e.id); end
      if (tx_data0 !== e.data) begin bad++; $display("FAIL g0_next_data got %h want %h", tx_data0, e.data); end
      req_valid0 = '0;
      repeat (3) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_busy_idle();
      test_reset_mid();
      test_gap0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter START_TO, default 16, max cycles from tx_start to tx_busy high.
REQ-003 SHALL have parameter GAP, default 2, idle cycles enforced between frames (0 allowed).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester byte-pending flag.
REQ-007 SHALL have port req_data  input  8*N_REQ  requester i byte on bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  N_REQ  one-cycle accept pulse to the granted requester.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to transmit, held from tx_start until the frame ends.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy flag, high while a frame is shifting.
REQ-012 SHALL have port grant_id  output  2  index of the current or last granted requester.
REQ-013 SHALL have port active  output  1  high in every state except IDLE.
REQ-014 SHALL have port err_timeout  output  1  one-cycle pulse when tx_busy fails to rise.

Function
REQ-015 SHALL implement states IDLE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-016 IDLE: when any req_valid=1 and tx_busy=0 at an edge, SHALL select the winner, latch its byte into tx_data, latch grant_id, and go to WAIT_BUSY.
REQ-017 The winner SHALL be chosen round-robin: search starts at last_grant+1 (mod N_REQ) and wraps, and the first valid requester found wins.
REQ-018 last_grant SHALL update to the winner on each grant.
REQ-019 In the first WAIT_BUSY cycle, req_ready[winner] and tx_start SHALL both be 1 for exactly one cycle; all other req_ready bits SHALL stay 0.
REQ-020 Latency: a valid seen at edge N SHALL give ready/tx_start high during cycle N+1.
REQ-021 IDLE with tx_busy=1 SHALL not grant; requests wait, with no loss and no ready pulse.
REQ-022 WAIT_BUSY: tx_busy=1 SHALL move the block to WAIT_DONE.
REQ-023 WAIT_BUSY: if tx_busy stays 0 for START_TO cycles after tx_start, the block SHALL pulse err_timeout for 1 cycle and go to GAP; the byte counts as consumed.
REQ-024 WAIT_DONE: tx_busy=0 SHALL move the block to GAP (or to IDLE if GAP=0).
REQ-025 GAP SHALL last exactly GAP cycles (8-bit counter), then the block SHALL return to IDLE.
REQ-026 req_valid/req_data SHALL be sampled only on the granting edge; changes at other times SHALL be ignored.
REQ-027 A requester holding valid after its ready pulse SHALL be treated as a new request at the next IDLE arbitration.
REQ-028 tx_data and grant_id SHALL stay stable outside the granting edge.
REQ-029 Only one transaction SHALL be outstanding at a time, with no queueing beyond the requester's own hold.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, including mid-frame in any state; any transmitter frame already started is not cancelled.
REQ-031 Reset values SHALL be: req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, active=0, err_timeout=0, GAP counter=0, timeout counter=0.
REQ-032 Reset SHALL set last_grant=N_REQ-1, so requester 0 wins first arbitration after reset.
REQ-033 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-034 Scenario: after reset, req_valid=3'b001 with data0=8'hA5, and a model raises tx_busy 2 cycles after tx_start for 10 cycles -> one cycle later req_ready=001, tx_start=1, tx_data=A5, grant_id=0; active drops 3 cycles after tx_busy falls (GAP=2).
REQ-035 Scenario: req_valid=3'b111 held constantly, with data 8'h11/8'h22/8'h33 -> the tx_data sequence is 11,22,33,11,22,33; each ready pulse is single-cycle and one-hot.
REQ-036 Scenario: tx_busy stuck at 0 -> err_timeout pulses exactly 16 cycles after tx_start, then GAP, then the next grant rotates to the next requester.
REQ-037 Scenario: tx_busy=1 during IDLE while req_valid=3'b010 -> no ready or tx_start until tx_busy=0; then grant_id=1 the next cycle.
REQ-038 Scenario: reset asserted in WAIT_DONE with req_valid=3'b100 pending -> the next cycle shows all outputs at reset values; after release, requester 2 is granted only once tx_busy=0.
REQ-039 Scenario: GAP=0 build with back-to-back requests -> the block goes straight from WAIT_DONE to IDLE, and the next tx_start comes 2 cycles after tx_busy falls.
